rv_lsu: RTL and testbench

- Parametrised load/store unit for the next-generation RV core.
- Replaces the core's zero-latency DRAM port with a valid/ready request/response bus that tolerates wait states.
- Handles byte, half, word (and double when XLEN=64) accesses, including byte-lane alignment, sign/zero extension and misalignment detection.
- Holds the core with a stall output while a transaction is in flight.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/rv_lsu_lane.sv | 46 ++++
 rtl/rv_lsu.sv | 167 ++++++++++++++++
 tb/tb_rv_lsu.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM/size encodings and decode helpers
// shared by rv_lsu and rv_lsu_lane.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  function automatic size_e size_of(logic [2:0] f3);
    return size_e'(f3[1:0]);
  endfunction

  function automatic logic f3_legal(logic we, logic [2:0] f3, logic x64);
    logic ok;
    if (we) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) ||
           (x64 && (f3 == F3_SD));
    end else begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU) ||
           (x64 && ((f3 == F3_LD) || (f3 == F3_LWU)));
    end
    return ok;
  endfunction

endpackage

// File: rtl/rv_lsu_lane.sv
// rv_lsu_lane: combinational byte-lane steering, load extension
// and alignment check for one access.
module rv_lsu_lane
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BW   = XLEN / 8,
  parameter int OW   = $clog2(XLEN / 8)
) (
  input  size_e           size,
  input  logic [OW-1:0]   off,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BW-1:0]   be,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned
);

  logic [XLEN-1:0] sh;
  logic            fill;
  int              nbits;

  always_comb begin
    sh        = rdata >> {off, 3'b000};
    fill      = 1'b0;
    nbits     = 8;
    rdata_ext = '0;
    unique case (size)
      SZ_B: begin nbits = 8;    fill = ~uns & sh[7];      end
      SZ_H: begin nbits = 16;   fill = ~uns & sh[15];     end
      SZ_W: begin nbits = 32;   fill = ~uns & sh[31];     end
      SZ_D: begin nbits = XLEN; fill = ~uns & sh[XLEN-1]; end
    endcase
    for (int i = 0; i < XLEN; i++) begin
      rdata_ext[i] = (i < nbits) ? sh[i] : fill;
    end
    be = BW'((32'd1 << (nbits / 8)) - 32'd1);
    be = be << off;
  end

  assign wdata_sh   = wdata << {off, 3'b000};
  assign misaligned = |(off & OW'((1 << int'(size)) - 1));

endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: valid/ready load/store unit with wait-state tolerant bus.
// Define LSU_TIMEOUT_EN to abort a bus access after MAX_WAIT cycles.
module rv_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  if (!(XLEN == 32 || XLEN == 64) || MAX_WAIT < 1) begin : g_bad_cfg
    $error("rv_lsu: XLEN must be 32 or 64, MAX_WAIT >= 1");
  end

  state_e          state;
  size_e           a_size;
  size_e           l_size;
  logic [OW-1:0]   a_off;
  logic [OW-1:0]   l_off;
  logic            a_uns;
  logic            a_we;
  logic            l_uns;
  logic [BW-1:0]   l_be;
  logic [XLEN-1:0] l_wdata;
  logic [XLEN-1:0] l_rdata;
  logic            l_mis;
  logic            idle;
  logic            busy;
  logic            legal;
  logic            fire;
  logic            tmo;

  assign idle      = (state == IDLE);
  assign busy      = (state == REQ) || (state == WAIT);
  assign req_ready = idle;
  assign stall     = (idle & req_valid) | busy;

  // Lane logic sees the live request while idle, the latched one after.
  assign l_size = idle ? size_of(req_funct3) : a_size;
  assign l_off  = idle ? req_addr[OW-1:0] : a_off;
  assign l_uns  = idle ? req_funct3[2] : a_uns;
  assign legal  = f3_legal(req_we, req_funct3, XLEN == 64);

  assign fire = ((state == REQ) & mem_req_ready & mem_rsp_valid) |
                ((state == WAIT) & mem_rsp_valid);

`ifdef LSU_TIMEOUT_EN
  localparam int CL = $clog2(MAX_WAIT + 1);
  localparam int CW = (CL > 8) ? CL : 8;

  logic [CW-1:0] cnt;

  assign tmo = busy & (cnt == CW'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  rv_lsu_lane #(.XLEN(XLEN)) u_lane (
    .size       (l_size),
    .off        (l_off),
    .uns        (l_uns),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .be         (l_be),
    .wdata_sh   (l_wdata),
    .rdata_ext  (l_rdata),
    .misaligned (l_mis)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_be        <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      a_size        <= SZ_B;
      a_off         <= '0;
      a_uns         <= 1'b0;
      a_we          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_size <= l_size;
            a_off  <= l_off;
            a_uns  <= l_uns;
            a_we   <= req_we;
            if (!legal || l_mis) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= req_we;
              mem_be        <= l_be;
              mem_addr      <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
              mem_wdata     <= l_wdata;
            end
          end
        end
        REQ, WAIT: begin
          if (fire) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_rdata     <= a_we ? '0 : l_rdata;
            mem_req_valid <= 1'b0;
          end else if (tmo) begin
            state         <= RESP;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            mem_req_valid <= 1'b0;
          end else if ((state == REQ) && mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: vector table, hand sequences and random traffic
// against a byte-arithmetic model of the load/store unit.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rv_lsu #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_be        (mem_be),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        rdy;
    int        rspd;
    bit        e_err;
    bit [3:0]  e_be;
    bit [31:0] e_wd;
    bit [31:0] e_rd;
  } vec_t;

  typedef struct {
    int          lat;
    int          nrsp;
    int          nstall;
    logic        err;
    logic [31:0] rd;
    bit          saw_req;
    bit          unstable;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
  } obs_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Spec-level model: sizes in bytes, offsets and masks by arithmetic.
  function automatic void ref_txn(input bit we, input bit [2:0] f3,
                                  input bit [31:0] addr, input bit [31:0] wdata,
                                  input bit [31:0] rdata, output bit err,
                                  output bit [3:0] be, output bit [31:0] wd,
                                  output bit [31:0] rd);
    int        n;
    int        off;
    bit        legal;
    bit [63:0] mask;
    bit [63:0] field;
    n     = 1 << f3[1:0];
    off   = addr % 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || ((addr % n) != 0);
    be    = 4'(((1 << n) - 1) << off);
    wd    = 32'(64'(wdata) << (8 * off));
    mask  = (64'd1 << (8 * n)) - 64'd1;
    field = (64'(rdata) >> (8 * off)) & mask;
    if (!f3[2] && field[8*n-1]) field = field | ~mask;
    rd = (err || we) ? 32'd0 : field[31:0];
  endfunction

  task automatic run_txn(input bit we, input bit [2:0] f3,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         input bit [31:0] rdata, input int rdy,
                         input int rspd, output obs_t o);
    int hs;
    int nreq;
    o.lat = -1; o.nrsp = 0; o.nstall = 0; o.err = 1'bx; o.rd = 'x;
    o.saw_req = 0; o.unstable = 0;
    o.we = 1'bx; o.be = 'x; o.addr = 'x; o.wd = 'x;
    hs = -1;
    nreq = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata;
    for (int c = 0; c < 80; c++) begin
      mem_req_ready = mem_req_valid && (nreq >= rdy);
      if (mem_req_valid) begin
        if (!o.saw_req) begin
          o.saw_req = 1; o.we = mem_we; o.be = mem_be;
          o.addr = mem_addr; o.wd = mem_wdata;
        end else if (o.we !== mem_we || o.be !== mem_be ||
                     o.addr !== mem_addr || o.wd !== mem_wdata) begin
          o.unstable = 1;
        end
        nreq++;
      end
      if (mem_req_ready && hs < 0) hs = c;
      mem_rsp_valid = (hs >= 0) && (c == hs + 1 + rspd);
      mem_rdata = rdata;
      #1;
      if (stall) o.nstall++;
      if (rsp_valid) begin
        o.nrsp++;
        if (o.lat < 0) begin
          o.lat = c; o.err = rsp_err; o.rd = rsp_rdata;
        end
        req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (o.lat >= 0 && c >= o.lat + 2) break;
    end
    req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
  endtask

  task automatic check_txn(input string t, input obs_t o, input bit e_err,
                           input bit [3:0] e_be, input bit [31:0] e_addr,
                           input bit [31:0] e_wd, input bit [31:0] e_rd,
                           input bit e_we, input int e_lat);
    chk({t, " rsp count"}, 64'(o.nrsp), 64'd1);
    chk({t, " latency"}, 64'(o.lat), 64'(e_lat));
    chk({t, " stall cycles"}, 64'(o.nstall), 64'(e_lat));
    chk({t, " err"}, 64'(o.err), 64'(e_err));
    chk({t, " rdata"}, 64'(o.rd), 64'(e_rd));
    chk({t, " bus req seen"}, 64'(o.saw_req), 64'(!e_err));
    if (!e_err) begin
      chk({t, " be"}, 64'(o.be), 64'(e_be));
      chk({t, " addr"}, 64'(o.addr), 64'(e_addr));
      chk({t, " wdata"}, 64'(o.wd), 64'(e_wd));
      chk({t, " we"}, 64'(o.we), 64'(e_we));
      chk({t, " held stable"}, 64'(o.unstable), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t      tbl[$];
    obs_t      o;
    bit        e_err;
    bit [3:0]  e_be;
    bit [31:0] e_wd;
    bit [31:0] e_rd;
    bit        r_we;
    bit [2:0]  r_f3;
    bit [31:0] r_addr;
    bit [31:0] r_wd;
    bit [31:0] r_rd;
    int        r_rdy;
    int        r_rspd;
    int        late;

    tbl.push_back('{1'b1, 3'd2, 32'h104, 32'h11223344, 32'h0, 0, 0,
                    1'b0, 4'hF, 32'h11223344, 32'h0});
    tbl.push_back('{1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0, 0,
                    1'b0, 4'h8, 32'h0, 32'hFFFFFF80});
    tbl.push_back('{1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 0, 0,
                    1'b0, 4'h8, 32'h0, 32'h00000080});
    tbl.push_back('{1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF0000, 1, 0,
                    1'b0, 4'hC, 32'h0, 32'hFFFF80FF});
    tbl.push_back('{1'b1, 3'd1, 32'h101, 32'hBEEF, 32'h0, 0, 0,
                    1'b1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 4, 1,
                    1'b0, 4'hF, 32'h0, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 3'd2, 32'h200, 32'h0, 32'h12345678, 0, -1,
                    1'b0, 4'hF, 32'h0, 32'h12345678});
    tbl.push_back('{1'b0, 3'd3, 32'h208, 32'h0, 32'h0, 0, 0,
                    1'b1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd6, 32'h208, 32'h0, 32'h0, 0, 0,
                    1'b1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd4, 32'h208, 32'h0, 32'h0, 0, 0,
                    1'b1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd5, 32'h106, 32'h0, 32'h80010000, 2, 2,
                    1'b0, 4'hC, 32'h0, 32'h00008001});
    tbl.push_back('{1'b1, 3'd1, 32'h10A, 32'hBEEF, 32'h0, 0, -1,
                    1'b0, 4'hC, 32'hBEEF0000, 32'h0});
    tbl.push_back('{1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, 0,
                    1'b1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 3'd7, 32'h100, 32'h0, 32'h0, 0, 0,
                    1'b1, 4'h0, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 3'd0, 32'h7, 32'h12345699, 32'h0, 0, 0,
                    1'b0, 4'h8, 32'h99000000, 32'h0});

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset mem_req_valid", 64'(mem_req_valid), 64'd0);
    chk("reset mem_we/be", 64'({mem_we, mem_be}), 64'd0);
    chk("reset mem_addr", 64'(mem_addr), 64'd0);
    chk("reset mem_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle req_ready", 64'(req_ready), 64'd1);
    chk("idle stall", 64'(stall), 64'd0);

    foreach (tbl[i]) begin
      run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
              tbl[i].rdata, tbl[i].rdy, tbl[i].rspd, o);
      check_txn($sformatf("vec%0d", i), o, tbl[i].e_err, tbl[i].e_be,
                tbl[i].addr & 32'hFFFF_FFFC, tbl[i].e_wd, tbl[i].e_rd,
                tbl[i].we,
                tbl[i].e_err ? 1 : 3 + tbl[i].rdy + tbl[i].rspd);
    end

    // Reset while waiting for read data; the late response must vanish.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h100; req_wdata = '0;
    @(posedge clk);
    #1;
    chk("rst seq req valid", 64'(mem_req_valid), 64'd1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_req_ready = 1'b0;
    chk("rst seq wait stall", 64'(stall), 64'd1);
    chk("rst seq req dropped", 64'(mem_req_valid), 64'd0);
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst seq outputs", 64'({rsp_valid, rsp_err, mem_req_valid,
                               mem_we, mem_be, rsp_rdata}), 64'd0);
    chk("rst seq addr/wdata", {mem_addr, mem_wdata}, 64'd0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    late = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (rsp_valid) late++;
    end
    chk("rst seq late rsp", 64'(late), 64'd0);
    chk("rst seq ready", 64'(req_ready), 64'd1);
    run_txn(1'b1, 3'd0, 32'h2, 32'h5A, 32'h0, 0, 0, o);
    check_txn("sb after rst", o, 1'b0, 4'h4, 32'h0, 32'h005A0000,
              32'h0, 1'b1, 3);

`ifdef LSU_TIMEOUT_EN
    run_txn(1'b0, 3'd2, 32'h300, 32'h0, 32'h1, 1000, 0, o);
    chk("timeout rsp count", 64'(o.nrsp), 64'd1);
    chk("timeout latency", 64'(o.lat), 64'd11);
    chk("timeout err", 64'(o.err), 64'd1);
    chk("timeout rdata", 64'(o.rd), 64'd0);
    chk("timeout req dropped", 64'(mem_req_valid), 64'd0);
    chk("timeout ready", 64'(req_ready), 64'd1);
`endif

    for (int i = 0; i < 60; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      r_rdy  = int'($urandom_range(0, 3));
      r_rspd = int'($urandom_range(0, 3)) - 1;
      ref_txn(r_we, r_f3, r_addr, r_wd, r_rd, e_err, e_be, e_wd, e_rd);
      run_txn(r_we, r_f3, r_addr, r_wd, r_rd, r_rdy, r_rspd, o);
      check_txn($sformatf("rnd%0d", i), o, e_err, e_be,
                r_addr & 32'hFFFF_FFFC, e_wd, e_rd, r_we,
                e_err ? 1 : 3 + r_rdy + r_rspd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
